// File: rtl/lfsr_gen.sv
// Parametrised Galois/Fibonacci LFSR with valid/ready output, seed load, input injection
// and all-zero lockup recovery. Define LFSR_PERIOD_CHECK_EN to add the period measurement outputs.
module lfsr_gen #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = 8'h2D,
    parameter logic [WIDTH-1:0] INIT  = 8'h80,
    parameter int               STEP  = 1,
    parameter int               MODE  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [STEP-1:0]  in,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [STEP-1:0]  out,
    output logic [WIDTH-1:0] state,
`ifdef LFSR_PERIOD_CHECK_EN
    output logic             period_done,
    output logic [WIDTH-1:0] period,
`endif
    output logic             lockup
);

    logic             fire;
    logic             update;
    logic             next_zero;
    logic [WIDTH-1:0] step_state;
    logic [WIDTH-1:0] next_state;

    // One sub-step; both modes shift right and emit s[0].
    function automatic logic [WIDTH-1:0] sub_step(input logic [WIDTH-1:0] s, input logic b);
        logic [WIDTH-1:0] r;
        if (MODE == 0) begin
            r = {b, s[WIDTH-1:1]};
            if (s[0])
                r = r ^ TAPS;
        end else begin
            r = {(^(s & TAPS)) ^ b, s[WIDTH-1:1]};
        end
        return r;
    endfunction

    assign out_valid = en;
    assign fire      = out_valid & out_ready;

    always_comb begin
        logic [WIDTH-1:0] s;
        s   = state;
        out = '0;
        for (int k = 0; k < STEP; k++) begin
            out[k] = s[0];
            s      = sub_step(s, in[k]);
        end
        step_state = s;
    end

    assign update     = load | fire;
    assign next_state = load ? seed : step_state;
    assign next_zero  = (next_state == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= INIT;
            lockup <= 1'b0;
        end else begin
            lockup <= update & next_zero;
            if (update)
                state <= next_zero ? INIT : next_state;
        end
    end

`ifdef LFSR_PERIOD_CHECK_EN
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] reference;

    // Reference is the state the measurement started from; a match closes one period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count       <= '0;
            reference   <= INIT;
            period      <= '0;
            period_done <= 1'b0;
        end else begin
            period_done <= 1'b0;
            if (load) begin
                count     <= '0;
                reference <= next_zero ? INIT : seed;
            end else if (fire) begin
                if (next_zero) begin
                    count     <= '0;
                    reference <= INIT;
                end else if (step_state == reference) begin
                    period      <= count + WIDTH'(1);
                    period_done <= 1'b1;
                    count       <= '0;
                end else begin
                    count <= count + WIDTH'(1);
                end
            end
        end
    end
`endif

endmodule
